// File: rtl/tone_player.sv
// Tone player: takes one note (prescale, duration) per handshake and plays it as a square wave
// and phase sample. A fixed silent gap follows, then note_done pulses.
module tone_player #(
    parameter int PRESCALE_W   = 10,
    parameter int PHASE_W      = 8,
    parameter int DUR_W        = 16,
    parameter int TICKS_PER_MS = 25000,
    parameter int GAP_MS       = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  note_valid,
    output logic                  note_ready,
    input  logic [PRESCALE_W-1:0] preScaleValue,
    input  logic [DUR_W-1:0]      duration_ms,
    input  logic                  stop,
    output logic                  sound_wave,
    output logic [PHASE_W-1:0]    sample,
    output logic                  playing,
    output logic                  note_done
);

    localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [PRESCALE_W-1:0] presc_q;
    logic [PRESCALE_W-1:0] pcnt;
    logic [PHASE_W-1:0]    phase;
    logic [TICK_W-1:0]     tick;
    logic [DUR_W-1:0]      ms_left;
    logic                  accept;
    logic                  ms_wrap;
    logic                  last_ms;
    logic                  done_nxt;

    // stop in IDLE swallows a concurrent request
    assign accept  = note_valid && (state == IDLE) && !stop;
    assign ms_wrap = (tick == TICK_W'(TICKS_PER_MS - 1));
    assign last_ms = ms_wrap && (ms_left == DUR_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (duration_ms != '0) begin
                        state_nxt = PLAY;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (last_ms) begin
                    if (GAP_MS == 0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (last_ms) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            pcnt      <= '0;
            phase     <= '0;
            tick      <= '0;
            ms_left   <= '0;
            note_done <= 1'b0;
        end else begin
            note_done <= done_nxt;
            if (accept) begin
                presc_q <= preScaleValue;
                pcnt    <= '0;
                phase   <= '0;
                tick    <= '0;
                ms_left <= duration_ms;
            end else if (state != IDLE) begin
                tick <= ms_wrap ? '0 : tick + TICK_W'(1);
                // the ms counter is reloaded with the gap length on the PLAY->GAP edge
                if (ms_wrap) begin
                    ms_left <= (state == PLAY && last_ms) ? DUR_W'(GAP_MS)
                                                          : ms_left - DUR_W'(1);
                end
                if (state == PLAY && presc_q != '0) begin
                    if (pcnt == presc_q - PRESCALE_W'(1)) begin
                        pcnt  <= '0;
                        phase <= phase + PHASE_W'(1);
                    end else begin
                        pcnt <= pcnt + PRESCALE_W'(1);
                    end
                end
            end
        end
    end

    // a rest (prescale 0) never steps the phase, so it stays silent here
    assign note_ready = (state == IDLE);
    assign playing    = (state != IDLE);
    assign sample     = (state == PLAY) ? phase : '0;
    assign sound_wave = (state == PLAY) && phase[PHASE_W-1];

endmodule

// File: tb/tb_tone_player.sv
// Bench for tone_player: directed and random notes compared cycle by cycle against a
// closed-form model of elapsed time since the accept edge.
module tb_tone_player;

    localparam int T = 64;
    localparam int G = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        note_valid;
    logic        note_ready;
    logic [9:0]  pre;
    logic [15:0] dur;
    logic        stop;
    logic        sound_wave;
    logic [7:0]  sample;
    logic        playing;
    logic        note_done;

    int checks = 0;
    int passes = 0;

    tone_player #(
        .PRESCALE_W(10),
        .PHASE_W(8),
        .DUR_W(16),
        .TICKS_PER_MS(T),
        .GAP_MS(G)
    ) dut (
        .clk(clk),
        .reset(reset),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .preScaleValue(pre),
        .duration_ms(dur),
        .stop(stop),
        .sound_wave(sound_wave),
        .sample(sample),
        .playing(playing),
        .note_done(note_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] obs();
        return {sound_wave, sample, playing, note_ready, note_done};
    endfunction

    // {sound_wave, sample, playing, note_ready, note_done}, j = edges since the accept edge
    function automatic logic [11:0] model(int p, int d, int j);
        logic [7:0] ph;
        if (d == 0) return (j == 0) ? 12'h003 : 12'h002;
        if (j < d * T) begin
            ph = (p == 0) ? 8'd0 : 8'((j / p) % 256);
            return {ph[7], ph, 1'b1, 1'b0, 1'b0};
        end
        if (j < (d + G) * T) return 12'h004;
        if (j == (d + G) * T) return 12'h003;
        return 12'h002;
    endfunction

    task automatic chk(string tag, logic [11:0] o, logic [11:0] e);
        checks++;
        assert (o === e) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic run(int p, int d, bit hold, int abort_at, bit use_reset);
        int jmax;
        jmax = (d == 0) ? 0 : (d + G) * T;
        note_valid = 1'b1;
        pre = 10'(p);
        dur = 16'(d);
        step();
        if (!hold) note_valid = 1'b0;
        for (int j = 0; j <= jmax; j++) begin
            if (j > 0) step();
            chk($sformatf("note p=%0d d=%0d j=%0d", p, d, j), obs(), model(p, d, j));
            if (hold) begin
                pre = 10'($urandom);
                dur = 16'($urandom);
            end
            if (j == abort_at) begin
                if (use_reset) reset = 1'b1;
                else stop = 1'b1;
                step();
                reset = 1'b0;
                stop = 1'b0;
                chk($sformatf("abort rst=%0d p=%0d d=%0d", use_reset, p, d), obs(), 12'h002);
                return;
            end
        end
        if (!hold) begin
            step();
            chk($sformatf("after p=%0d d=%0d", p, d), obs(), 12'h002);
        end
    endtask

    initial begin
        reset = 1'b1;
        note_valid = 1'b0;
        stop = 1'b0;
        pre = '0;
        dur = '0;
        repeat (3) step();
        chk("reset held", obs(), 12'h002);
        reset = 1'b0;
        step();
        chk("reset released", obs(), 12'h002);

        run(1, 5, 1'b0, -1, 1'b0);
        run(0, 2, 1'b0, -1, 1'b0);
        run(3, 0, 1'b0, -1, 1'b0);
        run(2, 3, 1'b0, 50, 1'b0);
        run(1, 1, 1'b0, -1, 1'b0);
        run(2, 2, 1'b0, 30, 1'b1);
        run(3, 1, 1'b0, -1, 1'b0);

        note_valid = 1'b1;
        stop = 1'b1;
        pre = 10'd5;
        dur = 16'd3;
        step();
        note_valid = 1'b0;
        stop = 1'b0;
        chk("stop in idle", obs(), 12'h002);
        step();
        chk("stop in idle later", obs(), 12'h002);

        run(2, 1, 1'b1, -1, 1'b0);
        run(3, 2, 1'b1, -1, 1'b0);
        run(0, 0, 1'b1, -1, 1'b0);
        run(1, 1, 1'b0, -1, 1'b0);

        repeat (8) begin
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), -1, 1'b0);
        end
        run(2, 1, 1'b0, -1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
